// File: rtl/vga_layer_mixer_if.sv
// Timing-in / layer-in / composited-out bundle for vga_layer_mixer.
// master drives the raw timing and layer inputs, slave is the mixer itself.
interface vga_layer_mixer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int CNT_W      = 11
);
    logic [CNT_W-1:0]              hcount_in, vcount_in;
    logic                          hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]         layer_valid, layer_en;
    logic [COLOR_W-1:0]            bg_rgb;

    logic [CNT_W-1:0]              hcount_out, vcount_out;
    logic                          hs_out, vs_out, hblnk_out, vblnk_out;
    logic [COLOR_W-1:0]            rgb_out;
    logic                          frame_start;
    logic [NUM_LAYERS-1:0]         coll_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               layer_rgb, layer_valid, layer_en, bg_rgb,
        input  hcount_out, vcount_out, hs_out, vs_out, hblnk_out, vblnk_out,
               rgb_out, frame_start, coll_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               layer_rgb, layer_valid, layer_en, bg_rgb,
        output hcount_out, vcount_out, hs_out, vs_out, hblnk_out, vblnk_out,
               rgb_out, frame_start, coll_out
    );
endinterface

// File: rtl/vga_layer_mixer.sv
// Fixed-priority layer compositor with aligned timing pipeline (latency 2+EXTRA_DELAY).
// Optional per-frame collision flags guarded by VGA_MIXER_COLLISION_EN.
module vga_layer_mixer #(
    parameter int NUM_LAYERS  = 4,
    parameter int COLOR_W     = 12,
    parameter int CNT_W       = 11,
    parameter int EXTRA_DELAY = 0,
    parameter int SYNC_INVERT = 0
) (
    input  logic             pclk,
    input  logic             rst_n,
    vga_layer_mixer_if.slave bus
);
    localparam int L = 2 + EXTRA_DELAY;

    typedef struct packed {
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] vc;
        logic             hs;
        logic             vs;
        logic             hb;
        logic             vb;
    } tim_t;

    tim_t                                tim   [1:L];
    logic [COLOR_W-1:0]                  rgb_p [2:L];
    logic [L:1]                          vld_pipe;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0]  layer_s1;
    logic [NUM_LAYERS-1:0]               valid_s1, en_s1, q1;
    logic [COLOR_W-1:0]                  bg_s1, rgb_c;
    logic                                blank_s1;

    assign q1       = valid_s1 & en_s1;
    assign blank_s1 = tim[1].hb | tim[1].vb;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= L; k++) tim[k] <= '0;
            for (int k = 2; k <= L; k++) rgb_p[k] <= '0;
            vld_pipe <= '0;
            layer_s1 <= '0;
            valid_s1 <= '0;
            en_s1    <= '0;
            bg_s1    <= '0;
        end else begin
            tim[1]   <= tim_t'{hc: bus.hcount_in, vc: bus.vcount_in,
                               hs: bus.hsync_in,  vs: bus.vsync_in,
                               hb: bus.hblnk_in,  vb: bus.vblnk_in};
            layer_s1 <= bus.layer_rgb;
            valid_s1 <= bus.layer_valid;
            en_s1    <= bus.layer_en;
            bg_s1    <= bus.bg_rgb;
            for (int k = 2; k <= L; k++) tim[k] <= tim[k-1];
            rgb_p[2] <= rgb_c;
            for (int k = 3; k <= L; k++) rgb_p[k] <= rgb_p[k-1];
            // Marks stages holding real post-reset data, so flushed zeros never look like (0,0).
            vld_pipe <= {vld_pipe[L-1:1], 1'b1};
        end
    end

    // Scan from lowest priority upward so the lowest qualifying index wins.
    always_comb begin
        rgb_c = bg_s1;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (q1[k]) rgb_c = layer_s1[k];
        end
        if (blank_s1) rgb_c = '0;
    end

`ifdef VGA_MIXER_COLLISION_EN
    logic [NUM_LAYERS-1:1] acc, coll, hit;
    logic                  vs_rise;

    assign hit     = blank_s1 ? '0 : (q1[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){q1[0]}});
    // tim[2] holds the previous S1 sample of the timing bus.
    assign vs_rise = tim[1].vs & ~tim[2].vs;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            coll <= '0;
        end else if (vs_rise) begin
            coll <= acc | hit;
            acc  <= '0;
        end else begin
            acc  <= acc | hit;
        end
    end

    assign bus.coll_out = {coll, 1'b0};
`else
    assign bus.coll_out = '0;
`endif

    assign bus.hcount_out  = tim[L].hc;
    assign bus.vcount_out  = tim[L].vc;
    assign bus.hs_out      = tim[L].hs ^ (SYNC_INVERT != 0);
    assign bus.vs_out      = tim[L].vs ^ (SYNC_INVERT != 0);
    assign bus.hblnk_out   = tim[L].hb;
    assign bus.vblnk_out   = tim[L].vb;
    assign bus.rgb_out     = rgb_p[L];
    assign bus.frame_start = vld_pipe[L] && (tim[L].hc == '0) && (tim[L].vc == '0);
endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised successor of the single-layer output stage.
- Takes the vga_timing bus plus NUM_LAYERS independently drawn pixel layers (palettes, ball, score, ...).
- Composites the layers by fixed priority over a programmable background, forces black during blanking, and delays sync/blank/counters by the same pipeline depth so all outputs stay aligned.
- Sits between the draw_* modules and the board VGA pins.

Parameters:
- NUM_LAYERS, 4: number of colour layers; layer 0 has the highest priority. Legal range 2..8.
- COLOR_W, 12: width of one RGB value (4:4:4).
- CNT_W, 11: width of hcount/vcount.
- EXTRA_DELAY, 0: additional register stages appended after compositing. Legal range 0..4.
- SYNC_INVERT, 0: 1 inverts hs_out and vs_out at the final stage.

Ports:
- pclk  in  1  pixel clock, 65 MHz.
- rst_n  in  1  asynchronous active-low reset.
- hcount_in  in  CNT_W  horizontal counter from vga_timing.
- vcount_in  in  CNT_W  vertical counter from vga_timing.
- hsync_in, vsync_in  in  1 each  raw sync signals.
- hblnk_in, vblnk_in  in  1 each  blanking signals.
- layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer colours; layer k occupies bits [k*COLOR_W +: COLOR_W].
- layer_valid  in  NUM_LAYERS  layer k has an opaque pixel at the current position.
- layer_en  in  NUM_LAYERS  static enable mask; sampled every cycle.
- bg_rgb  in  COLOR_W  background colour.
- hcount_out, vcount_out  out  CNT_W  aligned counters.
- hs_out, vs_out  out  1 each  aligned sync (after optional inversion).
- hblnk_out, vblnk_out  out  1 each  aligned blanking.
- rgb_out  out  COLOR_W  final pixel colour.
- frame_start  out  1  one-cycle pulse aligned with the output pixel (0,0).
- coll_out  out  NUM_LAYERS  per-frame collision flags; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline registers and outputs go to 0, with two exceptions. hs_out and vs_out reset to SYNC_INVERT. coll_out and the collision accumulator reset to 0.
- Stage 1 (S1) registers every input.
- Stage 2 (S2) computes rgb.
  - If S1 hblnk or vblnk is set, rgb = 0.
  - Otherwise rgb is the colour of the lowest index k with valid[k] & en[k].
  - If no layer qualifies, rgb = bg_rgb.
- Stages 3..2+EXTRA_DELAY copy all signals unchanged.
- Total latency is L = 2+EXTRA_DELAY cycles from input to every output; counters, sync, blank and rgb are all delayed by exactly L.
- Sync inversion and frame_start are combinational on the final register stage only; they add no extra cycle.
- frame_start = (hcount_out==0) && (vcount_out==0).
- Layers with en=0 are fully ignored, both for colour and for collision.
- A layer_valid pulse of a single cycle is honoured, with no minimum width.
- Counter values are passed through unmodified, with no wrap logic; wrap-around comes from vga_timing.
- Reset deasserted mid-frame: the output is valid after L cycles. frame_start fires only at the next true (0,0).

Optional Feature:
- Macro: VGA_MIXER_COLLISION_EN.
- When defined, a sticky accumulator acc[NUM_LAYERS-1:1] operates in S2:
  - acc[k] is set when S1 is not blanked and valid[0]&en[0]&valid[k]&en[k].
  - On the S1 cycle where vsync rises (0->1 versus the previous S1 value), coll_out <= acc (with any hit on that same cycle OR'd in), and acc clears to 0.
  - coll_out therefore holds the previous frame's result for one full frame.
- When not defined, no accumulator logic is synthesised and coll_out is constant 0.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles with random inputs -> rgb_out=0, hs_out=vs_out=SYNC_INVERT, frame_start=0, coll_out=0.
- Priority: layer_en=4'hF; valid=4'b0110; layer1=12'hF00, layer2=12'h0F0, bg=12'h00F -> rgb_out=12'hF00 exactly L cycles later. Then set en=4'b1101 -> 12'h0F0. Then valid=0 -> 12'h00F.
- Blanking: set hblnk_in=1 while valid=4'b0001 and layer0=12'hFFF -> rgb_out=0. hblnk_out and hs_out must track their inputs delayed by L, checked with EXTRA_DELAY=0 and 3.
- Alignment and frame_start: full 1344x806 frame from vga_timing -> frame_start high once per frame, coinciding with hcount_out=0 and vcount_out=0. SYNC_INVERT=1 gives hs_out = ~hsync delayed by L.
- Collision (macro on): overlap layer0 and layer2 for 3 pixels in frame N, with no overlap in frame N+1 -> coll_out=4'b0100 after the vsync rise ending frame N, then 4'b0000 after the one ending frame N+1. Macro off -> coll_out stays 0.
- Reset mid-frame: pulse rst_n low at line 300 -> outputs zero immediately (asynchronous). The next frame_start occurs at the following (0,0) with correct alignment.
